reg_file: RTL and testbench
===========================

# reg_file

MIPS general-purpose register file for the single-cycle datapath: 32 × 32-bit registers, two combinational read ports and one synchronous write port. The write side is a one-hot address decoder that steers write data to exactly one register; the read side selects among registers. It sits between the instruction decode fields (rs/rt/rd) and the ALU operand multiplexers, and is written by the writeback multiplexer output.

## Interface
- WIDTH, 32, register data width in bits.
- DEPTH_LOG2, 5, address width; register count is 2**DEPTH_LOG2.
- BYPASS, 0, 1 enables write-to-read forwarding in the same cycle.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable.
- waddr  input  DEPTH_LOG2  write register index.
- wdata  input  WIDTH  write data.
- raddr1  input  DEPTH_LOG2  read port 1 index (rs).
- raddr2  input  DEPTH_LOG2  read port 2 index (rt).
- rdata1  output  WIDTH  read port 1 data.
- rdata2  output  WIDTH  read port 2 data.

## Operation
- Storage: registers r1..r(2**DEPTH_LOG2 − 1). r0 has no storage and always reads 0.
- Write decode: waddr drives a one-hot select vector of 2**DEPTH_LOG2 bits. Bit 0 is forced to 0. A register loads wdata when we=1 and its select bit is 1. All other registers hold.
- Write to r0 (we=1, waddr=0): no state change, no error indication.
- Read: rdataN = 0 if raddrN = 0; otherwise the contents of register raddrN. Purely combinational from raddrN and register state.
- Bypass (BYPASS=1): if we=1, waddr≠0 and raddrN=waddr, then rdataN = wdata in the same cycle. With BYPASS=0, the read returns the old value until the edge.
- Both read ports may address the same register at the same time and return identical data.
- Reset: when rst=1 at a rising edge, all registers clear to 0. Reset takes priority over a simultaneous write; the write is dropped.

## Timing
- Write latency: 1 edge. Data presented with we=1 in cycle n is visible on the read ports (BYPASS=0) after the rising edge ending cycle n.
- Read latency: 0 cycles (combinational).
- Reset values: all registers 0, so rdata1 = rdata2 = 0 for any address after reset. Outputs are never X after the first reset edge.
- Reset mid-operation: any write pending in the reset cycle is discarded. Writes resume on the first edge with rst=0.
- Back-to-back writes to the same register: the last write wins, one per edge.
- No handshake; we is a single-cycle qualifier and is sampled every edge.

## Structure
- Shared package holds:
  - REG_ZERO = 0.
  - REG_RA = 31 (jal link target).
  - REG_SP = 29.
  - The default WIDTH and DEPTH_LOG2 constants, shared with the decode and writeback-mux logic.
- Sub-module `wr_decoder`: parameterised DEPTH_LOG2-to-one-hot decoder with an enable input and the bit-0 mask. It is the demultiplexing counterpart of the operand selectors, and is reusable for the data-memory byte-lane enables.
- Storage is an array of WIDTH-bit registers. Read selection uses indexed reads; no per-register output mux instances.

## Test plan
- Reset: assert rst for 1 edge with we=1, waddr=5, wdata=32'hDEADBEEF → r5 reads 0, and reads of all 32 addresses return 0.
- Basic write/read: we=1, waddr=8, wdata=32'h12345678, then deassert we → next cycle raddr1=8 gives 32'h12345678 and raddr2=9 gives 0.
- r0 immutability: we=1, waddr=0, wdata=32'hFFFFFFFF → raddr1=0 and raddr2=0 both return 0 afterwards.
- Same-cycle hazard: we=1, waddr=31, wdata=32'h00400008, raddr1=31 in the same cycle → BYPASS=0 returns the previous r31 value; BYPASS=1 returns 32'h00400008.
- Back-to-back and dual read: write r3 = 1, then r3 = 2, then r4 = 3 on consecutive edges → raddr1=3 gives 2, raddr2=4 gives 3; raddr1=raddr2=3 gives 2 on both ports.
- Full sweep: write ri = i × 32'h01010101 for i = 1..31, then read all pairs → every value matches and no register is aliased.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file constants for decode, writeback mux and storage.
// Holds architectural register indices and default geometry.
package reg_file_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH_LOG2 = 5;
    localparam int DEF_NREGS      = 2 ** DEF_DEPTH_LOG2;

    localparam logic [DEF_DEPTH_LOG2-1:0] REG_ZERO = 5'd0;
    localparam logic [DEF_DEPTH_LOG2-1:0] REG_SP   = 5'd29;
    localparam logic [DEF_DEPTH_LOG2-1:0] REG_RA   = 5'd31;

    typedef logic [DEF_DEPTH_LOG2-1:0] reg_idx_t;
    typedef logic [DEF_WIDTH-1:0]      reg_data_t;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_wr_decoder.sv
// Enabled binary-to-one-hot decoder with optional bit-0 mask.
// Also usable for data-memory byte-lane enables with MASK_ZERO=0.
module wr_decoder #(
    parameter int DEPTH_LOG2 = 5,
    parameter bit MASK_ZERO  = 1'b1
) (
    input  logic                     i_en,
    input  logic [DEPTH_LOG2-1:0]    i_addr,
    output logic [2**DEPTH_LOG2-1:0] o_sel
);

    always_comb begin
        o_sel = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
        if (MASK_ZERO) begin
            o_sel[0] = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS GPR file: 31 stored registers, r0 hardwired to zero.
// Two combinational read ports, one synchronous write port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr1,
    input  logic [DEPTH_LOG2-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2
);

    localparam int NREGS = 2 ** DEPTH_LOG2;
    localparam bit BYP   = (BYPASS != 0);

    logic [WIDTH-1:0] r_regs [1:NREGS-1];
    logic [NREGS-1:0] w_sel;
    logic             w_wr_nz;
    logic             w_hit1;
    logic             w_hit2;

    wr_decoder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .MASK_ZERO (1'b1)
    ) u_wr_decoder (
        .i_en  (we),
        .i_addr(waddr),
        .o_sel (w_sel)
    );

    // Reset wins over a same-edge write
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (w_sel[i]) begin
                r_regs[i] <= wdata;
            end
        end
    end

    assign w_wr_nz = we && (waddr != '0);
    assign w_hit1  = BYP && w_wr_nz && (raddr1 == waddr);
    assign w_hit2  = BYP && w_wr_nz && (raddr2 == waddr);

    always_comb begin
        rdata1 = '0;
        if (w_hit1) begin
            rdata1 = wdata;
        end else if (raddr1 != '0) begin
            rdata1 = r_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (w_hit2) begin
            rdata2 = wdata;
        end else if (raddr2 != '0) begin
            rdata2 = r_regs[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: BYPASS=0 and BYPASS=1 instances
// share stimulus; expectations are queued and checked on negedge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] b_rdata1;
    logic [31:0] b_rdata2;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] b1;
        logic [31:0] b2;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2)
    );

    reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) u_dut_byp (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(b_rdata1),
        .rdata2(b_rdata2)
    );

    task automatic cmp(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            cmp("rdata1", it.id, rdata1, it.e1);
            cmp("rdata2", it.id, rdata2, it.e2);
            cmp("byp_rdata1", it.id, b_rdata1, it.b1);
            cmp("byp_rdata2", it.id, b_rdata2, it.b2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic w, input logic [4:0] a,
                      input logic [31:0] d);
        we    = w;
        waddr = a;
        wdata = d;
    endtask

    task automatic chk4(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] b1, input logic [31:0] b2);
        exp_t it;
        raddr1 = a1;
        raddr2 = a2;
        it.e1 = e1;
        it.e2 = e2;
        it.b1 = b1;
        it.b2 = b2;
        it.id = tag++;
        sb.push_back(it);
        tick();
    endtask

    task automatic chk(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2);
        chk4(a1, a2, e1, e2, e1, e2);
    endtask

    initial begin
        rst    = 1'b1;
        raddr1 = '0;
        raddr2 = '0;
        wr(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        rst = 1'b0;
        wr(1'b0, 5'd0, 32'h0);

        // reset clears everything, write in reset cycle dropped
        for (int i = 0; i < 32; i++) begin
            chk(5'(i), 5'(31 - i), 32'h0, 32'h0);
        end

        wr(1'b1, 5'd8, 32'h12345678);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        chk(5'd8, 5'd9, 32'h12345678, 32'h0);

        // r0 write: never stored, never forwarded
        wr(1'b1, 5'd0, 32'hFFFFFFFF);
        chk(5'd0, 5'd0, 32'h0, 32'h0);
        wr(1'b0, 5'd0, 32'h0);
        chk(5'd0, 5'd0, 32'h0, 32'h0);

        // same-cycle hazard on r31
        wr(1'b1, 5'd31, 32'hCAFE0001);
        tick();
        wr(1'b1, 5'd31, 32'h00400008);
        chk4(5'd31, 5'd8, 32'hCAFE0001, 32'h12345678,
             32'h00400008, 32'h12345678);
        wr(1'b0, 5'd0, 32'h0);
        chk(5'd31, 5'd31, 32'h00400008, 32'h00400008);

        // back-to-back writes
        wr(1'b1, 5'd3, 32'd1);
        tick();
        wr(1'b1, 5'd3, 32'd2);
        tick();
        wr(1'b1, 5'd4, 32'd3);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        chk(5'd3, 5'd4, 32'd2, 32'd3);
        chk(5'd3, 5'd3, 32'd2, 32'd2);

        // reset mid-operation discards pending write
        rst = 1'b1;
        wr(1'b1, 5'd7, 32'hAAAA5555);
        tick();
        rst = 1'b0;
        wr(1'b0, 5'd0, 32'h0);
        chk(5'd7, 5'd3, 32'h0, 32'h0);
        chk(5'd31, 5'd8, 32'h0, 32'h0);

        // full sweep
        for (int i = 1; i < 32; i++) begin
            wr(1'b1, 5'(i), i * 32'h01010101);
            tick();
        end
        wr(1'b0, 5'd0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            int j;
            j = (i % 31) + 1;
            chk(5'(i), 5'(j), i * 32'h01010101, j * 32'h01010101);
        end
        chk(5'd0, 5'd29, 32'h0, 29 * 32'h01010101);

        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
